// File: rtl/spi_burst_ctrl_if.sv
// Upstream handshake and SPI-master side signals of the burst controller.
interface spi_burst_ctrl_if #(parameter int CNT_W = 8);
    logic             I_start;
    logic [CNT_W-1:0] I_len;
    logic             I_abort;
    logic [7:0]       I_tx_data;
    logic             I_tx_valid;
    logic             O_tx_ready;
    logic [7:0]       O_rx_data;
    logic             O_rx_valid;
    logic             O_busy;
    logic             O_done;
    logic             O_underrun;
    logic             O_spi_en;
    logic [7:0]       O_spi_data;
    logic [7:0]       I_spi_data_out;
    logic             I_spi_rx_done;

    modport slave (
        input  I_start, I_len, I_abort, I_tx_data, I_tx_valid,
        input  I_spi_data_out, I_spi_rx_done,
        output O_tx_ready, O_rx_data, O_rx_valid, O_busy, O_done,
        output O_underrun, O_spi_en, O_spi_data
    );

    modport master (
        output I_start, I_len, I_abort, I_tx_data, I_tx_valid,
        output I_spi_data_out, I_spi_rx_done,
        input  O_tx_ready, O_rx_data, O_rx_valid, O_busy, O_done,
        input  O_underrun, O_spi_en, O_spi_data
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst engine on top of the byte-level SPI master: keeps the
// master enabled for 16 cycles per byte and feeds it from a one-entry holding register.
module spi_burst_ctrl #(
    parameter int         CNT_W     = 8,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input logic             I_clk,
    input logic             I_rst_n,
    spi_burst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREP, XFER, DRAIN} state_t;

    state_t           state;
    logic [3:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       hold;
    logic             hold_valid;
    logic             spi_en;
    logic [7:0]       spi_data;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             done;
    logic             underrun;
    logic             rx_capture;

    assign bus.O_tx_ready = !hold_valid;
    assign bus.O_busy     = (state != IDLE);
    assign bus.O_spi_en   = spi_en;
    assign bus.O_spi_data = spi_data;
    assign bus.O_rx_data  = rx_data;
    assign bus.O_rx_valid = rx_valid;
    assign bus.O_done     = done;
    assign bus.O_underrun = underrun;

    // The master clears its RX outputs at the edge that ends DRAIN, so capture covers DRAIN too.
    assign rx_capture = bus.I_spi_rx_done && (state == XFER || state == DRAIN);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            remaining  <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            spi_en     <= 1'b0;
            spi_data   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;

            // Ready is low whenever a move is possible, so accept and move never collide.
            if (bus.I_tx_valid && !hold_valid) begin
                hold       <= bus.I_tx_data;
                hold_valid <= 1'b1;
            end

            if (bus.I_abort && state != IDLE) begin
                spi_en <= 1'b0;
                phase  <= '0;
                state  <= IDLE;
            end else begin
                if (rx_capture) begin
                    rx_data  <= bus.I_spi_data_out;
                    rx_valid <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (bus.I_start) begin
                            if (bus.I_len != '0) begin
                                remaining <= bus.I_len;
                                state     <= PREP;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    PREP: begin
                        if (hold_valid) begin
                            spi_data   <= hold;
                            hold_valid <= 1'b0;
                            phase      <= '0;
                            spi_en     <= 1'b1;
                            state      <= XFER;
                        end
                    end
                    XFER: begin
                        phase <= phase + 4'd1;
                        // phase 15 is the master's last state of the current byte
                        if (phase == 4'd15) begin
                            if (remaining == CNT_W'(1)) begin
                                spi_en <= 1'b0;
                                state  <= DRAIN;
                            end else begin
                                remaining <= remaining - CNT_W'(1);
                                if (hold_valid) begin
                                    spi_data   <= hold;
                                    hold_valid <= 1'b0;
                                end else begin
                                    spi_data <= FILL_BYTE;
                                    underrun <= 1'b1;
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl with a loopback model of the byte-level SPI master.
module tb_spi_burst_ctrl;
    localparam logic [7:0] FILL = 8'hFF;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    spi_burst_ctrl_if #(.CNT_W(8)) bus ();

    spi_burst_ctrl #(.CNT_W(8), .FILL_BYTE(FILL)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_rise_cyc = 0;
    int n_en = 0, n_rise = 0, n_rx = 0, n_ur = 0, n_solo = 0;
    logic en_prev = 1'b0;

    exp_t       sb_q[$];
    int         ur_q[$];
    logic [7:0] feed_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] new_bytes[$];
    bit         mosi_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-level SPI master model, MISO looped back to MOSI, MSB first, 2 cycles per bit.
    logic [3:0] m_cnt;
    logic [7:0] m_sh, m_rx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            m_sh  <= '0;
            m_rx  <= '0;
            bus.I_spi_rx_done  <= 1'b0;
            bus.I_spi_data_out <= '0;
        end else begin
            bus.I_spi_rx_done <= 1'b0;
            if (bus.O_spi_en) begin
                m_cnt <= m_cnt + 4'd1;
                if (m_cnt == 4'd0) m_sh <= bus.O_spi_data;
                if (m_cnt[0]) begin
                    m_rx <= {m_rx[6:0], m_sh[7]};
                    m_sh <= {m_sh[6:0], 1'b0};
                    mosi_q.push_back(m_sh[7]);
                end
                if (m_cnt == 4'd15) begin
                    bus.I_spi_rx_done  <= 1'b1;
                    bus.I_spi_data_out <= {m_rx[6:0], m_sh[7]};
                end
            end else begin
                m_cnt <= '0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte or an underrun.
    always @(negedge clk) begin
        exp_t e;
        if (bus.O_spi_en && !en_prev) begin
            en_rise_cyc = cyc;
            n_rise++;
        end
        en_prev = bus.O_spi_en;
        if (bus.O_spi_en) n_en++;
        if (bus.O_rx_valid) begin
            n_rx++;
            if (sb_q.size() == 0) fail_event("rx_unexpected");
            else begin
                e = sb_q.pop_front();
                check("rx_data", bus.O_rx_data, e.data);
                check("done_with_byte", bus.O_done, e.last);
                check("rx_offset", cyc - en_rise_cyc, 16 * e.k + 1);
            end
        end
        if (bus.O_done && !bus.O_rx_valid) n_solo++;
        if (bus.O_underrun) begin
            n_ur++;
            if (ur_q.size() == 0) fail_event("underrun_unexpected");
            else check("underrun_offset", cyc - en_rise_cyc, ur_q.pop_front());
        end
    end

    // Feeder: presents queued bytes over the valid/ready handshake.
    initial begin
        bus.I_tx_valid = 1'b0;
        bus.I_tx_data  = '0;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0) begin
                bus.I_tx_data  = feed_q[0];
                bus.I_tx_valid = 1'b1;
                if (bus.O_tx_ready) begin
                    @(posedge clk);
                    #1;
                    void'(feed_q.pop_front());
                    bus.I_tx_valid = 1'b0;
                end
            end else begin
                bus.I_tx_valid = 1'b0;
            end
        end
    end

    task automatic do_start(input int n);
        @(posedge clk); #1;
        bus.I_start = 1'b1;
        bus.I_len   = 8'(n);
        @(posedge clk); #1;
        bus.I_start = 1'b0;
    endtask

    task automatic queue_new_bytes();
        foreach (new_bytes[i]) begin
            feed_q.push_back(new_bytes[i]);
            pend_q.push_back(new_bytes[i]);
        end
        new_bytes.delete();
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.O_spi_en) begin ok = 1'b1; break; end
        end
        check("wait_en_timeout", ok, 1);
    endtask

    task automatic run_burst(input int n, input bit poke_start);
        int b_en, b_rise, b_rx, b_ur, b_solo, nu;
        bit ok;
        logic [7:0] b;
        queue_new_bytes();
        b_en = n_en; b_rise = n_rise; b_rx = n_rx; b_ur = n_ur; b_solo = n_solo;
        nu = 0;
        for (int k = 1; k <= n; k++) begin
            if (pend_q.size() > 0) b = pend_q.pop_front();
            else begin
                b = FILL;
                ur_q.push_back(16 * (k - 1));
                nu++;
            end
            sb_q.push_back('{data: b, last: (k == n), k: k});
        end
        do_start(n);
        if (poke_start) begin
            repeat (5) @(posedge clk); #1;
            bus.I_start = 1'b1;
            bus.I_len   = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            bus.I_start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 16 * n + 40; i++) begin
            @(posedge clk); #1;
            if (!bus.O_busy) begin ok = 1'b1; break; end
        end
        check("idle_timeout", ok, 1);
        repeat (3) @(posedge clk); #1;
        check("en_cycles", n_en - b_en, 16 * n);
        check("en_rises", n_rise - b_rise, 1);
        check("rx_count", n_rx - b_rx, n);
        check("underrun_count", n_ur - b_ur, nu);
        check("done_without_byte", n_solo - b_solo, 0);
        check("scoreboard_empty", sb_q.size(), 0);
        check("busy_after", bus.O_busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_en"}, bus.O_spi_en, 0);
        check({tag, "_spi_data"}, bus.O_spi_data, 0);
        check({tag, "_rx_data"}, bus.O_rx_data, 0);
        check({tag, "_rx_valid"}, bus.O_rx_valid, 0);
        check({tag, "_done"}, bus.O_done, 0);
        check({tag, "_underrun"}, bus.O_underrun, 0);
        check({tag, "_busy"}, bus.O_busy, 0);
        check({tag, "_tx_ready"}, bus.O_tx_ready, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rx, b_solo, b_rise, b_ur;
        bit ok;
        logic [7:0] pat;
        bus.I_start = 1'b0;
        bus.I_len   = '0;
        bus.I_abort = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte, loopback, MOSI bit order.
        mosi_q.delete();
        new_bytes = '{8'hA5};
        run_burst(1, 1'b0);
        pat = 8'hA5;
        check("mosi_bits", mosi_q.size(), 8);
        for (int i = 0; i < 8 && i < mosi_q.size(); i++) check("mosi_bit", mosi_q[i], pat[7 - i]);

        // Streamed three-byte burst.
        new_bytes = '{8'h01, 8'h80, 8'h3C};
        run_burst(3, 1'b0);

        // Underrun on the second byte.
        new_bytes = '{8'h5A};
        run_burst(2, 1'b0);

        // Zero-length start.
        b_solo = n_solo; b_rise = n_rise;
        do_start(0);
        check("len0_done", bus.O_done, 1);
        check("len0_busy", bus.O_busy, 0);
        @(posedge clk); #1;
        check("len0_done_pulse", bus.O_done, 0);
        repeat (20) @(posedge clk); #1;
        check("len0_en_rises", n_rise - b_rise, 0);
        check("len0_done_count", n_solo - b_solo, 1);

        // Abort at phase 7 of byte 2 of a 4-byte burst; the third byte stays held.
        new_bytes = '{8'hC3, 8'h96, 8'h4E};
        queue_new_bytes();
        b_rx = n_rx; b_solo = n_solo; b_ur = n_ur;
        sb_q.push_back('{data: pend_q.pop_front(), last: 1'b0, k: 1});
        void'(pend_q.pop_front());
        do_start(4);
        wait_en(ok);
        repeat (23) @(posedge clk); #1;
        bus.I_abort = 1'b1;
        @(posedge clk); #1;
        bus.I_abort = 1'b0;
        check("abort_en", bus.O_spi_en, 0);
        check("abort_busy", bus.O_busy, 0);
        repeat (40) @(posedge clk); #1;
        check("abort_rx_count", n_rx - b_rx, 1);
        check("abort_no_done", n_solo - b_solo, 0);
        check("abort_no_underrun", n_ur - b_ur, 0);
        check("abort_hold_kept", bus.O_tx_ready, 0);
        run_burst(1, 1'b0);

        // Randomized bursts, some with an ignored start mid-burst.
        for (int it = 0; it < 6; it++) begin
            int n, k;
            n = $urandom_range(1, 5);
            k = $urandom_range(1, n);
            for (int j = 0; j < k; j++) new_bytes.push_back(8'($urandom_range(0, 255)));
            run_burst(n, it[0]);
        end

        // Asynchronous reset mid-burst.
        new_bytes = '{8'h77};
        queue_new_bytes();
        pend_q.delete();
        do_start(3);
        wait_en(ok);
        repeat (10) @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        b_rx = n_rx; b_solo = n_solo; b_ur = n_ur;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk); #1;
        check("midreset_no_rx", n_rx - b_rx, 0);
        check("midreset_no_done", n_solo - b_solo, 0);
        check("midreset_no_underrun", n_ur - b_ur, 0);
        check("midreset_busy", bus.O_busy, 0);

        new_bytes = '{8'h12, 8'h34};
        run_burst(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

- Drives the byte-level SPI master from the upstream side and turns it into a multi-byte burst engine with chip select held low.
- Takes a burst length and a stream of TX bytes over a valid/ready handshake, holds the master enable for exactly 16 cycles per byte and re-presents each next byte on the master's byte boundary.
- Returns each received byte as a one-cycle valid pulse and signals the end of the burst.

## Interface
- CNT_W, 8: width of the burst-length field and the remaining-byte counter.
- FILL_BYTE, 8'hFF: byte transmitted when the TX holding register is empty at a byte boundary.

- I_clk  in  1  system clock (50 MHz, same domain as the SPI master)
- I_rst_n  in  1  asynchronous, active-low reset
- I_start  in  1  one-cycle burst start request, honoured only in IDLE
- I_len  in  CNT_W  number of bytes in the burst, sampled with I_start
- I_abort  in  1  terminate the burst immediately
- I_tx_data  in  8  next TX byte
- I_tx_valid  in  1  I_tx_data valid
- O_tx_ready  out  1  holding register empty; equals !hold_valid
- O_rx_data  out  8  last received byte
- O_rx_valid  out  1  one-cycle pulse, O_rx_data new; no backpressure
- O_busy  out  1  high in every state except IDLE
- O_done  out  1  one-cycle pulse, burst completed normally
- O_underrun  out  1  one-cycle pulse, FILL_BYTE substituted
- O_spi_en  out  1  to master enable
- O_spi_data  out  8  to master TX byte; stable for the whole byte
- I_spi_data_out  in  8  from master RX byte
- I_spi_rx_done  in  1  from master RX byte complete

## Operation
- **Holding register.** One 8-bit entry plus hold_valid.
  - An accept (I_tx_valid && O_tx_ready) occurs in any state, so the first byte can be preloaded in IDLE.
  - The register is emptied only when its byte moves into O_spi_data.
  - A move and an accept cannot happen in the same cycle, because ready is low whenever a move is possible.
- **Counters.** phase[3:0] mirrors the master's state counter. remaining[CNT_W-1:0] counts the bytes still to send.
- **IDLE**
  - I_start with I_len≠0: remaining<=I_len, go to PREP.
  - I_start with I_len==0: O_done pulses on the next cycle; stay in IDLE.
- **PREP**
  - If hold_valid: O_spi_data<=hold, hold_valid<=0, phase<=0, O_spi_en<=1, go to XFER.
  - Otherwise wait indefinitely; O_spi_en stays 0 and CS stays high.
- **XFER**
  - phase increments every cycle.
  - At phase==15 with remaining==1: O_spi_en<=0, go to DRAIN.
  - At phase==15 with remaining>1: remaining<=remaining-1 and phase wraps to 0.
    - If hold_valid, O_spi_data<=hold.
    - Otherwise O_spi_data<=FILL_BYTE and O_underrun pulses.
- **DRAIN**: lasts exactly one cycle, then go to IDLE with an O_done pulse.
- **RX capture** (XFER or DRAIN): when I_spi_rx_done==1, O_rx_data<=I_spi_data_out and O_rx_valid pulses. This happens once per byte.
- **I_abort** (PREP, XFER or DRAIN): next edge O_spi_en<=0, phase<=0, go to IDLE.
  - No O_done, no O_rx_valid.
  - The holding register is kept.
  - Abort has priority over every other action in that cycle.
- **I_start** while O_busy is high is ignored.
- **Asynchronous reset mid-burst**: all state clears. The master sees O_spi_en low on the following edge.

## Timing
- **Reset values**
  - O_spi_en 0, O_spi_data 0, O_rx_data 0, O_rx_valid 0, O_done 0, O_underrun 0, O_busy 0.
  - hold_valid 0, so O_tx_ready 1.
  - State IDLE; phase and remaining 0.
- **Timeline (edge E = the edge at which O_spi_en rises)**
  - I_start sampled at edge S with hold preloaded: PREP during S..S+1, and E = S+1.
  - O_spi_en is high for exactly 16·N cycles and falls at edge E+16N.
  - The master's first state-0 edge is E+1, and its state counter equals phase on every edge.
  - Byte k (k≥2) is loaded into O_spi_data at edge E+16(k−1), the master's state-15 edge of byte k−1.
- **Output timing**
  - O_rx_valid for byte k is high in the cycle after edge E+16k+1.
  - For the last byte, O_done is high in that same cycle.
  - The master clears its outputs at that edge, which is why capture happens in DRAIN.
- **Accept timing**: a TX byte accepted at edge A is eligible for the byte boundary at any edge ≥A+1.

## Test plan
- Preload 0xA5, I_start with I_len=1, loopback MISO=MOSI. Required:
  - O_spi_en high for exactly 16 cycles.
  - MOSI shows 1,0,1,0,0,1,0,1.
  - O_rx_data=0xA5 with O_rx_valid and O_done in the same cycle.
  - O_busy low afterwards.
- I_len=3, bytes 0x01,0x80,0x3C streamed with I_tx_valid always high. Required:
  - O_spi_en high for 48 contiguous cycles; CS never rises.
  - Three O_rx_valid pulses 16 cycles apart carrying 0x01,0x80,0x3C.
  - One O_done pulse.
- I_len=2 with only one TX byte supplied. Required:
  - Second byte transmitted as 0xFF.
  - O_underrun pulses once, at the second boundary (edge E+16).
- I_len=0 start. Required: O_done pulse one cycle later; O_spi_en never rises; O_busy stays low.
- I_abort asserted at phase 7 of byte 2 of a 4-byte burst. Required:
  - O_spi_en low on the next edge; state IDLE.
  - No further O_rx_valid pulses; no O_done.
  - A new I_start then runs normally.
- I_rst_n asserted mid-burst. Required:
  - Every output at its reset value immediately.
  - O_tx_ready=1.
  - No O_rx_valid or O_done pulse after release.
